uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. Each requester offers bytes on a valid/ready handshake; the arbiter picks one byte and launches the transmitter with a start pulse. It then tracks the transmitter's busy flag until the frame completes, and only then picks the next byte. It sits between on-chip message sources (status printers, debug dumpers) and the single `UART_TX` transmitter in the top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles to wait for `tx_busy` to rise after `tx_start` before flagging an error.
- `sysclk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: requester i has a byte.
- `req_data` in `8*NUM_REQ`: byte of requester i at bits [8i+7:8i].
- `req_last` in `NUM_REQ`: byte is the last of a message. Used only with lock; see Configuration.
- `req_ready` out `NUM_REQ`: one-hot. The byte of requester i is consumed in a cycle when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_data` out 8: byte presented to the transmitter. Registered; stable from the accept cycle until the next accept.
- `tx_start` out 1: one-cycle pulse requesting a frame.
- `tx_busy` in 1: transmitter is sending a frame.
- `grant_id` out `$clog2(NUM_REQ)`: index of the last accepted requester.
- `active` out 1: arbiter is not in IDLE.
- `err` out 1: sticky; `tx_busy` failed to rise within `BUSY_TIMEOUT` cycles. Cleared only by reset.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - Candidates are requesters with `req_valid` high (restricted further when locked; see Configuration).
  - The winner is the first candidate found searching from `ptr+1` upward, wrapping modulo `NUM_REQ`. `ptr` is the index of the last granted requester.
  - `req_ready[winner]` is driven combinationally high in the same cycle.
  - On that edge: `tx_data` takes the winner's byte, `grant_id` and `ptr` take the winner index, and the FSM moves to ISSUE.
  - With no candidate, the FSM stays in IDLE and `req_ready` is 0.
- **ISSUE:** `tx_start`=1 for exactly this cycle; the FSM moves to WAIT_BUSY and the timeout counter is cleared.
- **WAIT_BUSY:**
  - `tx_busy`=1 moves the FSM to WAIT_DONE.
  - Otherwise the timeout counter increments. When it reaches `BUSY_TIMEOUT`, `err` is set and the FSM returns to IDLE; the byte is dropped, not retried.
- **WAIT_DONE:** `tx_busy`=0 moves the FSM to IDLE.
- **Outside IDLE:** `req_ready` is all-zero in every other state.
- **Valid/ready rules:**
  - Requesters must hold `req_valid` and `req_data` until the byte is accepted.
  - The arbiter never asserts ready to a requester whose `req_valid` is low.
- **Simultaneous requests:** exactly one requester is accepted per frame, and a requester that wins is lowest priority at the next arbitration.
- **Width:** `ptr` and the timeout counter wrap by explicit compare, never by natural overflow.

## Timing
- **Reset values:**
  - `tx_start`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `active`=0, `err`=0.
  - `ptr`=`NUM_REQ-1`, so requester 0 wins first; the lock is cleared; the FSM is in IDLE.
- **Latency:**
  - Accept in cycle N; `tx_start` in cycle N+1.
  - The earliest next accept is the cycle after `tx_busy` is sampled low in WAIT_DONE.
  - Minimum gap between `tx_start` pulses: 3 cycles plus the busy duration.
- **Transmitter compatibility:** `tx_busy` may rise in the cycle after `tx_start`. A transmitter that samples start as a level is still correct, because `tx_start` falls before `tx_busy` falls.
- **Reset mid-frame:**
  - The FSM returns to IDLE immediately and the in-flight frame is abandoned by this block.
  - After reset the arbiter ignores `tx_busy` until the first accept.
- **Ready path:** `req_ready` is combinational from the FSM state and `req_valid`; all other outputs are registered.

## Configuration
- **Macro:** `UART_TX_ARB_LOCK_EN`.
- **Defined (message lock):**
  - Accepting a byte with `req_last`=0 sets the lock to that requester.
  - While locked, IDLE considers only the locked requester and stalls if its `req_valid` is low. Other requesters wait.
  - Accepting a byte with `req_last`=1 releases the lock.
  - Reset releases the lock.
  - A timeout `err` also releases the lock.
- **Undefined:** arbitration is per byte, `req_last` is ignored, and no lock state is built.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles with all `req_valid` high → `req_ready`=0, `tx_start`=0, `err`=0; after release, the first accept goes to requester 0.
- **Single byte:** requester 2 offers 8'h41, transmitter model busy for 20 cycles → `req_ready[2]` for 1 cycle, `tx_start` one cycle later with `tx_data`=8'h41, `grant_id`=2, `active` low after busy falls.
- **Round-robin fairness:** all 4 requesters continuously valid → grant order 0,1,2,3,0,1; exactly one `tx_start` per busy period, never while `tx_busy`=1.
- **Timeout:** the transmitter model never raises busy → `err`=1 after 16 cycles in WAIT_BUSY, FSM back to IDLE, and the next request is still served.
- **Lock (`UART_TX_ARB_LOCK_EN` defined):** requester 1 sends "HI\n" with `req_last` only on 8'h0A while requester 0 is valid throughout → bytes 8'h48, 8'h49, 8'h0A from requester 1 go out contiguously, then requester 0 is granted.
- **Reset mid-frame:** assert `rst_n`=0 during WAIT_DONE → next cycle `active`=0 and `tx_start`=0; the next accept restarts at requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Latency: byte accepted in cycle N, tx_start pulses in cycle N+1; next accept only after tx_busy falls.
// Backpressure: req_ready is one-hot and only raised in IDLE to a valid candidate; all others wait.
//
// Ports:
//   sysclk, rst_n            clock, synchronous active-low reset
//   req_valid/req_data/req_last/req_ready   per-requester byte handshake (byte i at [8i+7:8i])
//   tx_data, tx_start, tx_busy              transmitter interface
//   grant_id                 index of the last accepted requester
//   active                   FSM not in IDLE
//   err                      sticky: tx_busy did not rise within BUSY_TIMEOUT cycles
//
// Optional feature: define UART_TX_ARB_LOCK_EN to keep a requester granted until it sends
// a byte with req_last=1 (message lock). Without it, arbitration is per byte.

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             active_q, active_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [7:0]         win_byte;
  logic               accept;

`ifdef UART_TX_ARB_LOCK_EN
  logic             lock_vld_q, lock_vld_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
`else
  // req_last only matters for the message lock.
  logic             unused_req_last;
  assign unused_req_last = ^req_last;
`endif

  // Candidate set: everyone valid, or only the locked requester while a message is open.
  always_comb begin
    cand = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_vld_q) begin
      cand            = '0;
      cand[lock_id_q] = req_valid[lock_id_q];
    end
`endif
  end

  // Search from ptr+1 upward, wrapping by compare so the last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_byte  = 8'h00;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
        win_byte  = req_data[8*idx +: 8];
      end
    end
  end

  // rst_n gates the handshake so nothing is consumed while reset is held.
  assign accept = (state_q == IDLE) && rst_n && win_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
`ifdef UART_TX_ARB_LOCK_EN
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d  = win_byte;
          grant_d    = win_idx;
          ptr_d      = win_idx;
          tx_start_d = 1'b1;
          state_d    = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_vld_d = !req_last[win_idx];
          lock_id_d  = win_idx;
`endif
        end
      end
      ISSUE: begin
        // tx_busy is deliberately not looked at here; the transmitter may raise it next cycle.
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Counter would reach BUSY_TIMEOUT: give up, drop the byte, keep the error sticky.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_vld_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_q;
  assign active   = active_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16).
// The transmitter is modelled by driving tx_busy directly from the stimulus sequence.
// Outputs are sampled 2-3 time units after the rising edge.

module tb_uart_tx_arbiter;

  logic        sysclk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err;

  int total;
  int bad;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .err       (err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic set_byte(input int id, input logic [7:0] b);
    req_data[8*id +: 8] = b;
  endtask

  // Starts in IDLE with the expected winner already offered; runs one full frame.
  task automatic serve(input int id, input logic [7:0] d, input int busy_n, input bit drop);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << id;
    #1;
    chk("ready_onehot", {28'd0, req_ready}, {28'd0, exp_rdy});
    tick();
    if (drop) req_valid[id] = 1'b0;
    chk("issue_start", {31'd0, tx_start}, 32'd1);
    chk("issue_data", {24'd0, tx_data}, {24'd0, d});
    chk("issue_grant", {30'd0, grant_id}, id);
    chk("issue_active", {31'd0, active}, 32'd1);
    chk("issue_ready0", {28'd0, req_ready}, 32'd0);
    tick();
    chk("wb_start_low", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    for (int i = 0; i < busy_n; i++) begin
      tick();
      chk("busy_no_start", {31'd0, tx_start}, 32'd0);
      chk("busy_ready0", {28'd0, req_ready}, 32'd0);
    end
    tx_busy = 1'b0;
    tick();
    chk("done_inactive", {31'd0, active}, 32'd0);
    chk("done_data_held", {24'd0, tx_data}, {24'd0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_last  = 4'h0;
    tx_busy   = 1'b0;

    // Reset held with all requesters valid.
    repeat (5) tick();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    rst_n = 1'b1;

    // Round-robin with everyone continuously valid.
    serve(0, 8'hA0, 3, 1'b0);
    serve(1, 8'hA1, 3, 1'b0);
    serve(2, 8'hA2, 3, 1'b0);
    serve(3, 8'hA3, 3, 1'b0);
    serve(0, 8'hA0, 3, 1'b0);
    serve(1, 8'hA1, 3, 1'b0);

    // Single byte from requester 2, long busy.
    req_valid = 4'b0100;
    set_byte(2, 8'h41);
    serve(2, 8'h41, 20, 1'b1);
    chk("single_idle_ready0", {28'd0, req_ready}, 32'd0);

    // Timeout: transmitter never raises busy.
    req_valid = 4'b0001;
    set_byte(0, 8'hA0);
    #1;
    chk("to_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("to_start", {31'd0, tx_start}, 32'd1);
    tick();
    repeat (15) tick();
    chk("to_err_not_yet", {31'd0, err}, 32'd0);
    chk("to_still_active", {31'd0, active}, 32'd1);
    tick();
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_back_idle", {31'd0, active}, 32'd0);
    req_valid = 4'b0010;
    serve(1, 8'hA1, 2, 1'b1);
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset during WAIT_DONE.
    req_valid = 4'b1000;
    #1;
    chk("mid_ready", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0000;
    chk("mid_start", {31'd0, tx_start}, 32'd1);
    tick();
    tx_busy = 1'b1;
    tick();
    chk("mid_active", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_id}, 32'd0);
    rst_n     = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mid_restart_r0", {28'd0, req_ready}, 32'h1);
    tx_busy = 1'b0;
    serve(0, 8'hA0, 2, 1'b0);

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 1 sends "HI\n" while requester 0 stays valid.
    req_valid = 4'b0011;
    req_last  = 4'b0000;
    set_byte(1, 8'h48);
    serve(1, 8'h48, 2, 1'b0);
    set_byte(1, 8'h49);
    serve(1, 8'h49, 2, 1'b0);
    set_byte(1, 8'h0A);
    req_last[1] = 1'b1;
    serve(1, 8'h0A, 2, 1'b1);
    req_last = 4'b0000;
    serve(0, 8'hA0, 2, 1'b1);
`endif

    req_valid = 4'b0000;
    tick();
    chk("end_idle", {31'd0, active}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
